// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, ALU codes,
// state encodings, ALU B-operand selects and the control-vector type.
package mc_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_ANDI  = 4'd2;
  localparam logic [3:0] OP_ORI   = 4'd3;
  localparam logic [3:0] OP_NORI  = 4'd4;
  localparam logic [3:0] OP_BEQ   = 4'd5;
  localparam logic [3:0] OP_BNE   = 4'd6;
  localparam logic [3:0] OP_SLTI  = 4'd7;
  localparam logic [3:0] OP_LW    = 4'd8;
  localparam logic [3:0] OP_SW    = 4'd9;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] ASB_REG     = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_ALU_WB   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dest;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_NORI: return ALU_NOR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state/op_q -> datapath control-vector decoder.
// Only pc_write/ir_write/instr_done look at mem_ready or the illegal-NOP flag.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e      state_i,
  input  logic [3:0]  op_i,
  input  logic        mem_ready_i,
  input  logic        nop_done_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ASB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.ir_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b  = ASB_IMM_SH2;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.instr_done = nop_done_i;
      end
      ST_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_IMM;
        ctrl_o.alu_op    = imm_alu_op(op_i);
      end
      ST_ALU_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dest   = (op_i == OP_RTYPE);
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ASB_REG;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = 1'b1;
        ctrl_o.branch_ne     = (op_i == OP_BNE);
        ctrl_o.instr_done    = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: state register, latched opcode and next-state logic.
// Define MC_CONTROL_ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                pc_src,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                reg_dest,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic [3:0]          state
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                opc_legal;
  logic                nop_done;
  state_e              illegal_next;
  ctrl_t               ctrl;

  // Any bit above bit 3 also pushes the value past the last legal code.
  assign opc_legal = (opcode < OPCODE_W'(10));

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  assign illegal_next = ST_TRAP;
  assign nop_done     = 1'b0;
  assign illegal_op   = (state_q == ST_TRAP);
`else
  assign illegal_next = ST_FETCH;
  assign nop_done     = !opc_legal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = opcode;
        if (!opc_legal) begin
          state_d = illegal_next;
        end else begin
          case (opcode[3:0])
            OP_RTYPE:      state_d = ST_EXEC_R;
            OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = ST_BRANCH;
            default:       state_d = ST_EXEC_I;
          endcase
        end
      end
      ST_EXEC_R, ST_EXEC_I:             state_d = ST_ALU_WB;
      ST_ALU_WB, ST_MEM_WB, ST_BRANCH:  state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (op_q[3:0] == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_IDLE;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (op_q[3:0]),
    .mem_ready_i (mem_ready),
    .nop_done_i  (nop_done),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_src        = ctrl.pc_src;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign reg_dest      = ctrl.reg_dest;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALUOP_W'(ctrl.alu_op);
  assign instr_done    = ctrl.instr_done;
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm plus hand-written reset/illegal sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d;
  logic       mem_read, mem_write, mem_to_reg, reg_write, reg_dest, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       instr_done;
  logic [3:0] state;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  mc_control_fsm #(.OPCODE_W(4), .ALUOP_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_src        (pc_src),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dest      (reg_dest),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .state         (state)
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  // Control vector layout: 17 pcw,16 pcwc,15 bne,14 pcsrc,13 irw,12 iord,11 mr,
  // 10 mw,9 m2r,8 rw,7 rd,6 asa,[5:4] alu_src_b,[3:1] alu_op,0 done
  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d,
                mem_read, mem_write, mem_to_reg, reg_write, reg_dest, alu_src_a,
                alu_src_b, alu_op, instr_done};

  localparam logic [17:0] PCW   = 18'h20000;
  localparam logic [17:0] PCWC  = 18'h10000;
  localparam logic [17:0] BNE   = 18'h08000;
  localparam logic [17:0] PCSRC = 18'h04000;
  localparam logic [17:0] IRW   = 18'h02000;
  localparam logic [17:0] IORD  = 18'h01000;
  localparam logic [17:0] MR    = 18'h00800;
  localparam logic [17:0] MW    = 18'h00400;
  localparam logic [17:0] M2R   = 18'h00200;
  localparam logic [17:0] RW    = 18'h00100;
  localparam logic [17:0] RD    = 18'h00080;
  localparam logic [17:0] ASA   = 18'h00040;
  localparam logic [17:0] ASB4  = 18'h00010;
  localparam logic [17:0] ASBI  = 18'h00020;
  localparam logic [17:0] ASBS  = 18'h00030;
  localparam logic [17:0] A_SUB = 18'h00002;
  localparam logic [17:0] A_AND = 18'h00004;
  localparam logic [17:0] A_NOR = 18'h00008;
  localparam logic [17:0] A_SLT = 18'h0000A;
  localparam logic [17:0] A_FN  = 18'h0000E;
  localparam logic [17:0] DONE  = 18'h00001;

  localparam logic [17:0] FR    = MR | ASB4 | PCW | IRW;
  localparam logic [17:0] FW    = MR | ASB4;
  localparam logic [17:0] DEC   = ASBS;
  localparam logic [17:0] MADDR = ASA | ASBI;
  localparam logic [17:0] MRD   = MR | IORD;
  localparam logic [17:0] BR    = ASA | A_SUB | PCWC | PCSRC | DONE;

  typedef struct packed {
    logic [3:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic mr, input logic [3:0] st,
                     input logic [17:0] c);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  initial begin
    // Opcode 4'hF on non-DECODE rows shows the input is ignored there.
    add(4'hF, 1'b1, 4'd0,  18'h0);               // IDLE
    add(4'hF, 1'b1, 4'd1,  FR);                  // FETCH
    add(4'h0, 1'b1, 4'd2,  DEC);                 // DECODE add
    add(4'hF, 1'b1, 4'd3,  ASA | A_FN);          // EXEC_R
    add(4'hF, 1'b1, 4'd5,  RW | RD | DONE);      // ALU_WB (R)
    add(4'hF, 1'b0, 4'd1,  FW);                  // FETCH wait
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h8, 1'b1, 4'd2,  DEC);                 // lw
    add(4'hF, 1'b0, 4'd6,  MADDR);
    add(4'hF, 1'b0, 4'd7,  MRD);
    add(4'hF, 1'b0, 4'd7,  MRD);
    add(4'hF, 1'b1, 4'd7,  MRD);
    add(4'hF, 1'b0, 4'd8,  RW | M2R | DONE);
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h9, 1'b1, 4'd2,  DEC);                 // sw
    add(4'hF, 1'b1, 4'd6,  MADDR);
    add(4'hF, 1'b0, 4'd9,  MW | IORD);
    add(4'hF, 1'b1, 4'd9,  MW | IORD | DONE);
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h6, 1'b1, 4'd2,  DEC);                 // bne
    add(4'hF, 1'b1, 4'd10, BR | BNE);
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h5, 1'b1, 4'd2,  DEC);                 // beq
    add(4'hF, 1'b1, 4'd10, BR);
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h4, 1'b1, 4'd2,  DEC);                 // nori
    add(4'hF, 1'b1, 4'd4,  ASA | ASBI | A_NOR);
    add(4'hF, 1'b1, 4'd5,  RW | DONE);
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h7, 1'b1, 4'd2,  DEC);                 // slti
    add(4'hF, 1'b1, 4'd4,  ASA | ASBI | A_SLT);
    add(4'hF, 1'b1, 4'd5,  RW | DONE);
    add(4'hF, 1'b1, 4'd1,  FR);
    add(4'h2, 1'b1, 4'd2,  DEC);                 // andi
    add(4'hF, 1'b1, 4'd4,  ASA | ASBI | A_AND);
    add(4'hF, 1'b1, 4'd5,  RW | DONE);

    rst_n = 1'b0; opcode = 4'h0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset state", 32'(state), 32'd0);
    chk("reset ctl",   32'(ctl),   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("row%0d ctl", i),   32'(ctl),   32'(vecs[i].ctl));
      @(negedge clk);
    end

    // Async reset in the middle of EXEC_I.
    opcode = 4'hF; mem_ready = 1'b1; #1;
    chk("pre-rst fetch", 32'(state), 32'd1);
    @(negedge clk); opcode = 4'h4;
    @(negedge clk); opcode = 4'hF; #1;
    chk("pre-rst exec_i", 32'(state), 32'd4);
    rst_n = 1'b0; #1;
    chk("async rst state", 32'(state), 32'd0);
    chk("async rst ctl",   32'(ctl),   32'd0);
    @(negedge clk);
    chk("held rst state", 32'(state), 32'd0);
    rst_n = 1'b1; #1;
    chk("post-rst idle", 32'(state), 32'd0);
    @(negedge clk); #1;
    chk("post-rst fetch", 32'(state), 32'd1);

    // Illegal opcode 1100.
    @(negedge clk); opcode = 4'hC; #1;
    chk("ill decode state", 32'(state), 32'd2);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    chk("ill decode ctl", 32'(ctl), 32'(DEC));
    @(negedge clk); opcode = 4'h0; #1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("trap%0d state", k), 32'(state), 32'd11);
      chk($sformatf("trap%0d illegal_op", k), 32'(illegal_op), 32'd1);
      chk($sformatf("trap%0d ctl", k), 32'(ctl), 32'd0);
      @(negedge clk); #1;
    end
    rst_n = 1'b0; #1;
    chk("trap rst state", 32'(state), 32'd0);
    chk("trap rst illegal_op", 32'(illegal_op), 32'd0);
    @(negedge clk); rst_n = 1'b1;
`else
    chk("ill decode ctl", 32'(ctl), 32'(DEC | DONE));
    @(negedge clk); opcode = 4'hF; #1;
    chk("ill next fetch", 32'(state), 32'd1);
    chk("ill fetch ctl",  32'(ctl),   32'(FR));
    // Opcode 1010: first illegal code.
    @(negedge clk); opcode = 4'hA; #1;
    chk("ill10 decode ctl", 32'(ctl), 32'(DEC | DONE));
    @(negedge clk); opcode = 4'h0; #1;
    chk("ill10 next fetch", 32'(state), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
